// File: rtl/conv_ctrl_pkg.sv
// Shared types and helpers for the conv layer sequencer.
package conv_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DONE} seq_state_t;

  // Upper bound on kernel count supported by group_mask.
  localparam int MAX_K = 256;

  // Zero pixels needed after the last real pixel so an NxN window fully drains.
  function automatic int flush_pixels(input int n, input int w);
    return ((n - 1) / 2) * w + (n - 1) / 2;
  endfunction

  // Kernel-enable mask for one group: pe consecutive bits starting at group*pe.
  function automatic logic [MAX_K-1:0] group_mask(input int group, input int pe, input int nk);
    logic [MAX_K-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_K; i++)
      if (i >= group * pe && i < (group + 1) * pe && i < nk) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/pixel_position_counter.sv
// Row/column position of the pixel currently being issued.
module pixel_position_counter #(
  parameter int ImageWidth = 8,
  parameter int CW         = $clog2(ImageWidth)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  input  logic          clear,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last_col,
  output logic          last_pixel
);

  localparam logic [CW-1:0] LAST = CW'(ImageWidth - 1);

  assign last_col   = (col == LAST);
  assign last_pixel = last_col && (row == LAST);

  // Raster-order position; clear has priority over advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (last_col) begin
        col <= '0;
        row <= (row == LAST) ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Holds each pixel for CyclesPerPixel issue cycles (one kernel group per
// cycle), then drains the line buffers with zero flush pixels per frame.
module conv_layer_sequencer
  import conv_ctrl_pkg::*;
#(
  parameter int BitSize            = 4,
  parameter int N                  = 3,
  parameter int ImageWidth         = 8,
  parameter int NumberOfK          = 8,
  parameter int CyclesPerPixel     = 4,
  parameter int ProcessingElements = 2,
  parameter int GW                 = (CyclesPerPixel > 1) ? $clog2(CyclesPerPixel) : 1,
  parameter int PW                 = $clog2(ImageWidth)
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 in_valid,
  input  logic [BitSize-1:0]   in_data,
  output logic                 in_ready,
  input  logic                 pe_ready,
  output logic                 pe_valid,
  output logic [BitSize-1:0]   pe_data,
  output logic [GW-1:0]        pe_group,
  output logic [NumberOfK-1:0] pe_k_valid,
  output logic                 pe_flush,
  output logic [PW-1:0]        row,
  output logic [PW-1:0]        col,
  output logic                 line_end,
  output logic                 frame_end
);

  localparam int              FP         = flush_pixels(N, ImageWidth);
  localparam int              FW         = $clog2(FP + 1);
  localparam logic [GW-1:0]   GRP_LAST   = GW'(CyclesPerPixel - 1);
  localparam logic [FW-1:0]   FLUSH_LAST = FW'(FP - 1);

  if (NumberOfK != CyclesPerPixel * ProcessingElements) begin : g_cfg_pe
    $error("ProcessingElements must equal NumberOfK/CyclesPerPixel");
  end
  if (N < 3 || (N % 2) == 0) begin : g_cfg_n
    $error("N must be odd and at least 3");
  end

  seq_state_t           state, state_n;
  logic [GW-1:0]        group, group_n;
  logic [BitSize-1:0]   pix, pix_n;
  logic [FW-1:0]        flush_cnt, flush_n;
  logic                 adv, clr;
  logic                 last_grp, last_pix, last_col, hs, accept;

  pixel_position_counter #(.ImageWidth(ImageWidth), .CW(PW)) u_pos (
    .clk       (clk),
    .rst       (res_n),
    .advance   (adv),
    .clear     (clr),
    .row       (row),
    .col       (col),
    .last_col  (last_col),
    .last_pixel(last_pix)
  );

  assign pe_valid   = (state == ISSUE) || (state == FLUSH);
  assign hs         = pe_valid && pe_ready;
  assign last_grp   = (group == GRP_LAST);
  // Offering ready on the last group lets the next pixel follow with no bubble.
  assign in_ready   = (state == IDLE) ||
                      ((state == ISSUE) && last_grp && pe_ready && !last_pix);
  assign accept     = in_valid && in_ready;
  assign pe_data    = (state == ISSUE) ? pix : '0;
  assign pe_group   = group;
  assign pe_flush   = (state == FLUSH);
  assign pe_k_valid = pe_valid ? NumberOfK'(group_mask(int'(group), ProcessingElements, NumberOfK))
                               : '0;
  assign line_end   = hs && last_grp && last_col && (state == ISSUE);
  assign frame_end  = (state == DONE);

  // State and issue registers.
  always_ff @(posedge clk or posedge res_n) begin
    if (res_n) begin
      state     <= IDLE;
      group     <= '0;
      pix       <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_n;
      group     <= group_n;
      pix       <= pix_n;
      flush_cnt <= flush_n;
    end
  end

  // Next-state: group sequencing, pixel hand-over and flush counting.
  always_comb begin
    state_n = state;
    group_n = group;
    pix_n   = pix;
    flush_n = flush_cnt;
    adv     = 1'b0;
    clr     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          pix_n   = in_data;
          group_n = '0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (pe_ready) begin
          if (!last_grp) begin
            group_n = group + GW'(1);
          end else begin
            group_n = '0;
            // Position stays on the last pixel so flush reports the frame corner.
            adv = !last_pix;
            if (accept) begin
              pix_n = in_data;
            end else if (last_pix) begin
              state_n = FLUSH;
              flush_n = '0;
            end else begin
              state_n = IDLE;
            end
          end
        end
      end
      FLUSH: begin
        if (pe_ready) begin
          if (!last_grp) begin
            group_n = group + GW'(1);
          end else begin
            group_n = '0;
            if (flush_cnt == FLUSH_LAST) state_n = DONE;
            else                         flush_n = flush_cnt + FW'(1);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        flush_n = '0;
        clr     = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Scoreboard bench: stimulus queues expected issues, a negedge monitor checks them.
module tb_conv_layer_sequencer;

  logic       clk = 1'b0;
  logic       res_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       pe_ready = 1'b1;
  logic       in_ready, pe_valid, pe_flush, line_end, frame_end;
  logic [3:0] pe_data;
  logic [1:0] pe_group;
  logic [7:0] pe_k_valid;
  logic [2:0] row, col;

  conv_layer_sequencer dut (
    .clk       (clk),
    .res_n     (res_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .pe_ready  (pe_ready),
    .pe_valid  (pe_valid),
    .pe_data   (pe_data),
    .pe_group  (pe_group),
    .pe_k_valid(pe_k_valid),
    .pe_flush  (pe_flush),
    .row       (row),
    .col       (col),
    .line_end  (line_end),
    .frame_end (frame_end)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic [1:0] grp;
    logic [7:0] mask;
    logic       flush;
    logic [2:0] row;
    logic [2:0] col;
    logic       le;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0, n_pass = 0;
  int   fe_count = 0, cur_run = 0, fe_run = 0;
  logic [7:0] mask_tab [4] = '{8'h03, 8'h0C, 8'h30, 8'hC0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pixel(input int k, input logic [3:0] d);
    exp_t e;
    for (int g = 0; g < 4; g++) begin
      e.data = d; e.grp = 2'(g); e.mask = mask_tab[g]; e.flush = 1'b0;
      e.row = 3'(k / 8); e.col = 3'(k % 8); e.le = (g == 3) && (k % 8 == 7);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_flush();
    exp_t e;
    for (int p = 0; p < 9; p++)
      for (int g = 0; g < 4; g++) begin
        e.data = 4'h0; e.grp = 2'(g); e.mask = mask_tab[g]; e.flush = 1'b1;
        e.row = 3'd7; e.col = 3'd7; e.le = 1'b0;
        exp_q.push_back(e);
      end
  endtask

  // Present a pixel and return just after the edge that accepts it.
  task automatic send(input logic [3:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL send_timeout: in_ready stayed 0 for pixel %0h", d);
    end
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 1000) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [3:0] pdat(input int k);
    return 4'((k * 5 + 3) & 15);
  endfunction

  // Monitor: compare every handshake against the queue head; track runs and frame_end.
  always @(negedge clk) begin
    if (res_n) begin
      cur_run = 0;
    end else begin
      if (frame_end) begin
        fe_count++;
        fe_run = cur_run;
      end
      if (pe_valid) cur_run++;
      else          cur_run = 0;
      if (!pe_valid) chk("k_valid_idle", 32'(pe_k_valid), 32'd0);
      if (pe_valid && pe_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_issue: data=%0h group=%0d row=%0d col=%0d", pe_data, pe_group, row, col);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pe_data",    32'(pe_data),    32'(mon_e.data));
          chk("pe_group",   32'(pe_group),   32'(mon_e.grp));
          chk("pe_k_valid", 32'(pe_k_valid), 32'(mon_e.mask));
          chk("pe_flush",   32'(pe_flush),   32'(mon_e.flush));
          chk("row",        32'(row),        32'(mon_e.row));
          chk("col",        32'(col),        32'(mon_e.col));
          chk("line_end",   32'(line_end),   32'(mon_e.le));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pe_valid"},   32'(pe_valid),   32'd0);
    chk({tag, "_pe_data"},    32'(pe_data),    32'd0);
    chk({tag, "_pe_group"},   32'(pe_group),   32'd0);
    chk({tag, "_pe_k_valid"}, 32'(pe_k_valid), 32'd0);
    chk({tag, "_pe_flush"},   32'(pe_flush),   32'd0);
    chk({tag, "_line_end"},   32'(line_end),   32'd0);
    chk({tag, "_frame_end"},  32'(frame_end),  32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    @(negedge clk);
    chk_all_zero("rst");
    tick();
    res_n = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Frame 1: group sweep on pixel 0
    push_pixel(0, 4'h7);
    send(4'h7);
    in_valid = 1'b0;
    drain();

    // Pixel 1: stall three cycles in group 2
    push_pixel(1, 4'h9);
    send(4'h9);
    in_valid = 1'b0;
    tick();
    tick();
    pe_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(pe_valid),   32'd1);
      chk("stall_group", 32'(pe_group),   32'd2);
      chk("stall_mask",  32'(pe_k_valid), 32'h30);
      chk("stall_data",  32'(pe_data),    32'h9);
      chk("stall_row",   32'(row),        32'd0);
      chk("stall_col",   32'(col),        32'd1);
      chk("stall_ready", 32'(in_ready),   32'd0);
      tick();
    end
    pe_ready = 1'b1;
    drain();

    // Pixel 2 then a one-cycle bubble before pixel 3
    push_pixel(2, 4'h2);
    send(4'h2);
    in_valid = 1'b0;
    drain();
    push_pixel(3, 4'hE);
    in_valid = 1'b1;
    in_data  = 4'hE;
    @(negedge clk);
    chk("bubble_valid", 32'(pe_valid), 32'd0);
    chk("bubble_ready", 32'(in_ready), 32'd1);
    tick();
    @(negedge clk);
    chk("bubble_resume", 32'(pe_valid), 32'd1);
    tick();

    // Rest of frame 1 streamed (covers row wrap at pixel 7 -> 8)
    for (int k = 4; k < 64; k++) begin
      push_pixel(k, pdat(k));
      send(pdat(k));
    end
    in_valid = 1'b0;
    push_flush();
    drain();
    repeat (3) tick();
    chk("frame1_end_count", 32'(fe_count), 32'd1);

    // Frame 2: fully continuous, 292 contiguous issue cycles
    for (int k = 0; k < 64; k++) begin
      push_pixel(k, pdat(k + 1));
      send(pdat(k + 1));
    end
    in_valid = 1'b0;
    push_flush();
    drain();
    repeat (3) tick();
    chk("frame2_end_count", 32'(fe_count), 32'd2);
    chk("frame2_run_len",   32'(fe_run),   32'd292);
    @(negedge clk);
    chk("idle_after_frame", 32'(in_ready), 32'd1);
    tick();

    // Frame 3: reset during the 20th pixel (row 2, col 3)
    for (int k = 0; k < 20; k++) begin
      push_pixel(k, pdat(k + 2));
      send(pdat(k + 2));
    end
    in_valid = 1'b0;
    tick();
    tick();
    res_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk_all_zero("midrst");
    tick();
    res_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_no_fe",    32'(fe_count), 32'd2);
    tick();
    push_pixel(0, 4'hA);
    send(4'hA);
    in_valid = 1'b0;
    drain();
    repeat (2) tick();
    chk("post_rst_no_fe", 32'(fe_count), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
